// File: rtl/obi_sram_responder_pkg.sv
// Shared types for the OBI SRAM responder: bus structs, response pipeline entry,
// grant FSM states and the error read-data pattern.
package obi_sram_responder_pkg;

    localparam logic [31:0] ErrRdata = 32'hBADCAB1E;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } resp_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANT
    } gnt_state_e;

endpackage

// File: rtl/obi_resp_delay_line.sv
// Fixed-depth response shift register; an entry pushed in cycle t appears on
// out_o in cycle t+DEPTH. Reset clears every stage so no stale rvalid survives.
module obi_resp_delay_line
    import obi_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 1,
    parameter type         entry_t = resp_entry_t
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  entry_t           in_i,
    output entry_t           out_o,
    output logic [DEPTH-1:0] vld_o
);

    entry_t stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_o = stage_q[DEPTH-1];

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_vld
        assign vld_o[g] = stage_q[g].valid;
    end

endmodule

// File: rtl/obi_sram_responder.sv
// OBI responder terminating one port onto a word-addressed byte-enable SRAM,
// with a programmable grant wait and a fixed-latency in-order response pipeline.
module obi_sram_responder
    import obi_sram_responder_pkg::*;
#(
    parameter int unsigned NUM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned GNT_WAIT     = 0,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  slave_req_i,
    output obi_resp_t slave_resp_o,
    input  logic      stall_i,
    output logic      addr_err_o
);

    localparam int unsigned AW       = $clog2(NUM_WORDS);
    localparam logic [32:0] MemBytes = 33'(NUM_WORDS) << 2;
    localparam logic [3:0]  CntLoad  = (GNT_WAIT > 0) ? 4'(GNT_WAIT - 1) : 4'd0;

    gnt_state_e        state_q;
    logic [3:0]        cnt_q;
    logic              gnt;
    logic              accept;
    logic [31:0]       off;
    logic [AW-1:0]     idx;
    logic              oor;
    resp_entry_t       entry_in;
    resp_entry_t       entry_out;
    logic [RESP_LATENCY-1:0] vld;
    logic [31:0]       mem_q [NUM_WORDS];

    // With no wait the grant is purely combinational; otherwise it comes from
    // the registered GRANT state, still masked live by stall_i.
    assign gnt = rst_ni && !stall_i &&
                 ((GNT_WAIT == 0) ? slave_req_i.req : (state_q == GRANT));
    assign accept = slave_req_i.req && gnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else if (GNT_WAIT != 0) begin
            case (state_q)
                IDLE: begin
                    if (slave_req_i.req && !stall_i) begin
                        state_q <= WAIT;
                        cnt_q   <= CntLoad;
                    end
                end
                WAIT: begin
                    if (!slave_req_i.req)  state_q <= IDLE;
                    else if (cnt_q == 4'd0) state_q <= GRANT;
                    else                    cnt_q   <= cnt_q - 4'd1;
                end
                GRANT: begin
                    if (!slave_req_i.req || !stall_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Subtract-then-compare so a base near the top of the map wraps correctly.
    assign off = slave_req_i.addr - BASE_ADDR;
    assign idx = off[2 +: AW];
    assign oor = {1'b0, off} >= MemBytes;

    always_comb begin
        entry_in       = '0;
        entry_in.valid = accept;
        entry_in.err   = accept && oor;
        if (accept) begin
            if (oor)                   entry_in.rdata = ErrRdata;
            else if (!slave_req_i.we)  entry_in.rdata = mem_q[idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && slave_req_i.we && !oor) begin
            for (int b = 0; b < 4; b++) begin
                if (slave_req_i.be[b]) mem_q[idx][8*b +: 8] <= slave_req_i.wdata[8*b +: 8];
            end
        end
    end

    obi_resp_delay_line #(
        .DEPTH   (RESP_LATENCY),
        .entry_t (resp_entry_t)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .in_i   (entry_in),
        .out_o  (entry_out),
        .vld_o  (vld)
    );

    assign slave_resp_o.gnt    = gnt;
    assign slave_resp_o.rvalid = entry_out.valid;
    assign slave_resp_o.rdata  = entry_out.rdata;
    assign addr_err_o          = entry_out.err;

`ifndef SYNTHESIS
    logic [31:0] gnt_cnt_q;
    logic [31:0] rv_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gnt_cnt_q <= 32'd0;
            rv_cnt_q  <= 32'd0;
        end else begin
            gnt_cnt_q <= gnt_cnt_q + 32'(accept);
            rv_cnt_q  <= rv_cnt_q + 32'(entry_out.valid);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) a_inflight: assert (gnt_cnt_q - rv_cnt_q == 32'($countones(vld)));
    end

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slave_req_i.req && !gnt) |=>
        (slave_req_i.req && $stable(slave_req_i.addr) && $stable(slave_req_i.we) &&
         $stable(slave_req_i.be) && $stable(slave_req_i.wdata)));
`endif

endmodule

// File: tb/tb_obi_sram_responder.sv
// Directed bench: three responder configurations (default, GNT_WAIT=3,
// RESP_LATENCY=3) driven from a vector table plus hand-written timing sequences.
module tb_obi_sram_responder;
    import obi_sram_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic      rst_a, rst_b, rst_c;
    logic      stall_a, stall_b, stall_c;
    obi_req_t  req_a, req_b, req_c;
    obi_resp_t resp_a, resp_b, resp_c;
    logic      err_a, err_b, err_c;

    obi_sram_responder u_a (
        .clk_i(clk), .rst_ni(rst_a), .slave_req_i(req_a), .slave_resp_o(resp_a),
        .stall_i(stall_a), .addr_err_o(err_a));

    obi_sram_responder #(.NUM_WORDS(16), .GNT_WAIT(3)) u_b (
        .clk_i(clk), .rst_ni(rst_b), .slave_req_i(req_b), .slave_resp_o(resp_b),
        .stall_i(stall_b), .addr_err_o(err_b));

    obi_sram_responder #(.NUM_WORDS(16), .RESP_LATENCY(3)) u_c (
        .clk_i(clk), .rst_ni(rst_c), .slave_req_i(req_c), .slave_resp_o(resp_c),
        .stall_i(stall_c), .addr_err_o(err_c));

    int checks = 0;
    int errors = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    function automatic obi_req_t mk(input logic we, input logic [3:0] be,
                                    input logic [31:0] addr, input logic [31:0] wdata);
        obi_req_t r;
        r.req = 1'b1; r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    // Waits (bounded) for gnt on u_b, raising stall_b only in cycle stall_at.
    task automatic wait_gnt_b(input int stall_at, output int n);
        n = -1;
        for (int k = 0; k < 20; k++) begin
            stall_b = (k == stall_at);
            #1;
            if (resp_b.gnt) begin
                n = k;
                break;
            end
            @(negedge clk);
        end
        stall_b = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        vt[0]  = '{1'b1, 4'hF, 32'h0000_0000, 32'h0102_0304, 32'h0,          1'b0};
        vt[1]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
        vt[2]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[3]  = '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0,          1'b0};
        vt[4]  = '{1'b1, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 32'h0,          1'b0};
        vt[5]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0};
        vt[6]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,         32'hBADC_AB1E, 1'b1};
        vt[7]  = '{1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 32'hBADC_AB1E, 1'b1};
        vt[8]  = '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         32'h0102_0304, 1'b0};
        vt[9]  = '{1'b0, 4'hF, 32'h0000_0013, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[10] = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,         32'hBADC_AB1E, 1'b1};
        vt[11] = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         32'h11BB_33DD, 1'b0};

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        stall_a = 1'b0; stall_b = 1'b0; stall_c = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        repeat (2) @(negedge clk);
        #1;
        chk1 ("rst_gnt",    resp_a.gnt,    1'b0);
        chk1 ("rst_rvalid", resp_a.rvalid, 1'b0);
        chk32("rst_rdata",  resp_a.rdata,  32'h0);
        chk1 ("rst_err",    err_a,         1'b0);
        chk1 ("rst_rvalid_c", resp_c.rvalid, 1'b0);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

        // Default config: single transactions, gnt same cycle, rvalid one later.
        for (int i = 0; i < 12; i++) begin
            req_a = mk(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata);
            #1;
            chk1("vec_gnt", resp_a.gnt, 1'b1);
            @(negedge clk);
            #1;
            req_a = '0;
            chk1 ("vec_rvalid", resp_a.rvalid, 1'b1);
            chk32("vec_rdata",  resp_a.rdata,  vt[i].exp_rdata);
            chk1 ("vec_err",    err_a,         vt[i].exp_err);
        end

        // Read-after-write on consecutive cycles.
        req_a = mk(1'b1, 4'hF, 32'h40, 32'hCAFE_F00D);
        #1;
        chk1("raw_wr_gnt", resp_a.gnt, 1'b1);
        @(negedge clk);
        #1;
        chk1 ("raw_wr_rvalid", resp_a.rvalid, 1'b1);
        chk32("raw_wr_rdata",  resp_a.rdata,  32'h0);
        req_a = mk(1'b0, 4'hF, 32'h40, 32'h0);
        #1;
        chk1("raw_rd_gnt", resp_a.gnt, 1'b1);
        @(negedge clk);
        #1;
        req_a = '0;
        chk1 ("raw_rd_rvalid", resp_a.rvalid, 1'b1);
        chk32("raw_rd_rdata",  resp_a.rdata,  32'hCAFE_F00D);
        #1;
        chk1("idle_rvalid", resp_a.rvalid, 1'b1);
        @(negedge clk);
        #1;
        chk1("idle_rvalid_low", resp_a.rvalid, 1'b0);

        // GNT_WAIT=3: gnt four cycles after req, five with a one-cycle stall in GRANT.
        req_b = mk(1'b1, 4'hF, 32'h8, 32'h55AA_55AA);
        wait_gnt_b(-1, n);
        chk32("b_wr_gnt_lat", 32'(n), 32'd4);
        @(negedge clk);
        #1;
        req_b = '0;
        chk1 ("b_wr_rvalid", resp_b.rvalid, 1'b1);
        chk32("b_wr_rdata",  resp_b.rdata,  32'h0);
        req_b = mk(1'b0, 4'hF, 32'h8, 32'h0);
        wait_gnt_b(4, n);
        chk32("b_rd_gnt_lat", 32'(n), 32'd5);
        chk1 ("b_rd_rvalid_early", resp_b.rvalid, 1'b0);
        @(negedge clk);
        #1;
        req_b = '0;
        chk1 ("b_rd_rvalid", resp_b.rvalid, 1'b1);
        chk32("b_rd_rdata",  resp_b.rdata,  32'h55AA_55AA);

        // RESP_LATENCY=3: preload words 0..3, then four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            req_c = mk(1'b1, 4'hF, 32'(i * 4), 32'(i));
            @(negedge clk);
        end
        req_c = '0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k < 4) req_c = mk(1'b0, 4'hF, 32'(k * 4), 32'h0);
            else       req_c = '0;
            #1;
            chk1("c_gnt",    resp_c.gnt,    k < 4);
            chk1("c_rvalid", resp_c.rvalid, (k >= 3) && (k <= 6));
            if ((k >= 3) && (k <= 6)) chk32("c_rdata", resp_c.rdata, 32'(k - 3));
            @(negedge clk);
        end

        // Reset one cycle after a grant drops the in-flight response.
        req_c = mk(1'b0, 4'hF, 32'h8, 32'h0);
        #1;
        chk1("c_pre_rst_gnt", resp_c.gnt, 1'b1);
        @(negedge clk);
        rst_c = 1'b0;
        req_c = mk(1'b0, 4'hF, 32'h4, 32'h0);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) rst_c = 1'b1;
            if (k == 3) req_c = '0;
            #1;
            chk1("c_rst_rvalid", resp_c.rvalid, 1'b0);
            if (k < 2)  chk1("c_rst_gnt", resp_c.gnt, 1'b0);
            if (k == 2) chk1("c_rel_gnt", resp_c.gnt, 1'b1);
            @(negedge clk);
        end
        #1;
        chk1 ("c_post_rst_rvalid", resp_c.rvalid, 1'b1);
        chk32("c_post_rst_rdata",  resp_c.rdata,  32'h1);
        chk1 ("c_post_rst_err",    err_c,         1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
